// File: rtl/fdiv_seq.sv
// fdiv_seq: single-precision divider y = x1 / x2, computed as x1 * (1/x2).
// The reciprocal comes from an external finv block driven through finv_x/finv_y.
// Optional feature macro: FDIV_DZ_FLAG_EN adds a divide-by-zero flag output dz.
// One operation in flight; request/response use valid/ready handshakes.

module fdiv_seq #(
    parameter int FINV_LAT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] y,
    output logic [31:0] finv_x,
    input  logic [31:0] finv_y
`ifdef FDIV_DZ_FLAG_EN
    ,
    output logic        dz
`endif
);

    localparam int CNT_W = $clog2(FINV_LAT + 1);
    // finv_y settles FINV_LAT edges after finv_x; it is sampled on the edge after that.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FINV_LAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        x1_q, x1_d;
    logic [31:0]        finv_x_q, finv_x_d;
    logic [31:0]        inv_q, inv_d;
    logic [31:0]        y_q, y_d;
`ifdef FDIV_DZ_FLAG_EN
    logic               dz_q, dz_d;
`endif

    // Quotient datapath signals
    logic [47:0]        prod;
    logic signed [9:0]  e_sum;
    logic [22:0]        mant;
    logic               q_sign;
    logic [31:0]        quot;
    logic               unused_prod_lsbs;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == CNT_LAST) state_d = ST_MUL;
            ST_MUL:  state_d = ST_DONE;
            ST_DONE: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_DONE);
    end

    // Truncating multiply of x1 by the captured reciprocal, with special cases
    always_comb begin
        prod   = 48'({1'b1, x1_q[22:0]}) * 48'({1'b1, inv_q[22:0]});
        q_sign = x1_q[31] ^ inv_q[31];
        e_sum  = $signed({2'b00, x1_q[30:23]}) + $signed({2'b00, inv_q[30:23]})
                 - (prod[47] ? 10'sd126 : 10'sd127);
        mant   = prod[47] ? prod[46:24] : prod[45:23];
        if (finv_x_q[30:23] == 8'h00) begin
            // Division by zero (or denormal divisor): signed infinity
            quot = {x1_q[31] ^ finv_x_q[31], 8'hFF, 23'h0};
        end else if (x1_q[30:23] == 8'h00) begin
            quot = {q_sign, 31'h0};
        end else if (e_sum >= 10'sd255) begin
            quot = {q_sign, 8'hFF, 23'h0};
        end else if (e_sum <= 10'sd0) begin
            quot = {q_sign, 31'h0};
        end else begin
            quot = {q_sign, e_sum[7:0], mant};
        end
    end

    // Bits below the truncation point are dropped (round toward zero)
    assign unused_prod_lsbs = ^prod[22:0];

    // Datapath register next values
    always_comb begin
        cnt_d    = cnt_q;
        x1_d     = x1_q;
        finv_x_d = finv_x_q;
        inv_d    = inv_q;
        y_d      = y_q;
`ifdef FDIV_DZ_FLAG_EN
        dz_d     = dz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    x1_d     = x1;
                    finv_x_d = x2;
                    cnt_d    = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    inv_d = finv_y;
                end
            end
            ST_MUL: begin
                y_d = quot;
`ifdef FDIV_DZ_FLAG_EN
                dz_d = (finv_x_q[30:23] == 8'h00) && (x1_q[30:23] != 8'h00);
`endif
            end
            ST_DONE: begin
`ifdef FDIV_DZ_FLAG_EN
                if (resp_ready) dz_d = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q    <= '0;
            x1_q     <= '0;
            finv_x_q <= '0;
            inv_q    <= '0;
            y_q      <= '0;
`ifdef FDIV_DZ_FLAG_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            x1_q     <= x1_d;
            finv_x_q <= finv_x_d;
            inv_q    <= inv_d;
            y_q      <= y_d;
`ifdef FDIV_DZ_FLAG_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign y      = y_q;
    assign finv_x = finv_x_q;
`ifdef FDIV_DZ_FLAG_EN
    assign dz     = dz_q;
`endif

endmodule

// File: tb/tb_fdiv_seq.sv
// Bench for fdiv_seq: behavioural finv pipeline, directed vector table,
// exponent sweep with ulp tolerance, and multi-cycle handshake/reset sequences.

module tb_fdiv_seq;

    localparam int FINV_LAT = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] a1, a2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] y;
    logic [31:0] finv_x;
    logic [31:0] finv_y;
    logic        dz_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fdiv_seq #(.FINV_LAT(FINV_LAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .x1         (a1),
        .x2         (a2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .y          (y),
        .finv_x     (finv_x),
        .finv_y     (finv_y)
`ifdef FDIV_DZ_FLAG_EN
        ,
        .dz         (dz_w)
`endif
    );
`ifndef FDIV_DZ_FLAG_EN
    assign dz_w = 1'b0;
`endif

    // ---------- single-precision helpers built on double reals ----------
    function automatic real from_single(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'h00) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] to_single(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:52] == 11'h000) return {d[63], 31'h0};
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        if (e <= 0) return {d[63], 31'h0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] inv_model(input logic [31:0] x);
        if (x[30:23] == 8'h00) return {x[31], 8'hFF, 23'h0};
        return to_single(1.0 / from_single(x));
    endfunction

    function automatic int ulp_dist(input logic [31:0] a, input logic [31:0] b);
        int d;
        if (a[31] != b[31]) return (a[30:0] == 0 && b[30:0] == 0) ? 0 : 1 << 30;
        d = int'({1'b0, a[30:0]}) - int'({1'b0, b[30:0]});
        return (d < 0) ? -d : d;
    endfunction

    // ---------- behavioural finv: FINV_LAT register stages ----------
    logic [31:0] finv_pipe [FINV_LAT];
    always @(posedge clk) begin
        finv_pipe[0] <= inv_model(finv_x);
        for (int i = 1; i < FINV_LAT; i++) finv_pipe[i] <= finv_pipe[i-1];
    end
    assign finv_y = finv_pipe[FINV_LAT-1];

    // ---------- checking ----------
    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One full operation; returns quotient and dz. hold=1 leaves resp_ready low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                          output logic [31:0] yv, output logic dzv);
        int lat;
        @(negedge clk);
        a1 = a; a2 = b; req_valid = 1'b1; resp_ready = !hold;
        chk("req_ready_idle", req_ready == 1'b1, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("finv_x_latched", finv_x == b, finv_x, b);
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat == FINV_LAT + 2, 32'(lat), 32'(FINV_LAT + 2));
        yv = y; dzv = dz_w;
        $display("op x1=%08h x2=%08h -> y=%08h dz=%0d lat=%0d", a, b, y, dz_w, lat);
        if (!hold) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] exp_y;
        int          tol;
        logic        exp_dz;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] yv, refy, bx1, bx2, ref_y0;
        logic        dzv;
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        logic [31:0] pexp [3];
        logic [31:0] got [3];
        int          idx, nresp;
        bit          rdy, rv, seen;

        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 3, 1'b0}; // 6/2
        vecs[1] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 0, 1'b1}; // 1/0
        vecs[2] = '{32'h80000000, 32'h3F800000, 32'h80000000, 0, 1'b0}; // -0/1
        vecs[3] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 0, 1'b0}; // overflow
        vecs[4] = '{32'h00800000, 32'h7F000000, 32'h00000000, 0, 1'b0}; // underflow
        vecs[5] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3, 1'b0}; // 1/3
        vecs[6] = '{32'hC1200000, 32'h40800000, 32'hC0200000, 3, 1'b0}; // -10/4
        vecs[7] = '{32'h40E00000, 32'hBF000000, 32'hC1600000, 3, 1'b0}; // 7/-0.5
        vecs[8] = '{32'h80000000, 32'h00000000, 32'hFF800000, 0, 1'b0}; // -0/0

        rstn = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; a1 = '0; a2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready == 1'b1, 32'(req_ready), 32'd1);
        chk("rst_resp_valid", resp_valid == 1'b0, 32'(resp_valid), 32'd0);
        chk("rst_y", y == 32'h0, y, 32'h0);
        chk("rst_finv_x", finv_x == 32'h0, finv_x, 32'h0);
        chk("rst_dz", dz_w == 1'b0, 32'(dz_w), 32'd0);
        @(negedge clk); rstn = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].x1, vecs[i].x2, 1'b0, yv, dzv);
            chk($sformatf("vec%0d_y", i), ulp_dist(yv, vecs[i].exp_y) <= vecs[i].tol, yv, vecs[i].exp_y);
`ifdef FDIV_DZ_FLAG_EN
            chk($sformatf("vec%0d_dz", i), dzv == vecs[i].exp_dz, 32'(dzv), 32'(vecs[i].exp_dz));
`endif
        end

        // Backpressure: resp_ready low for 5 cycles after resp_valid
        run_op(32'h40C00000, 32'h40000000, 1'b1, yv, dzv);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_resp_valid", resp_valid == 1'b1, 32'(resp_valid), 32'd1);
            chk("bp_y_stable", y == yv, y, yv);
            chk("bp_req_ready", req_ready == 1'b0, 32'(req_ready), 32'd0);
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_after_hs_req_ready", req_ready == 1'b1, 32'(req_ready), 32'd1);
        chk("bp_after_hs_resp_valid", resp_valid == 1'b0, 32'(resp_valid), 32'd0);

        // Reset while in WAIT aborts the operation
        @(negedge clk);
        a1 = 32'h40C00000; a2 = 32'h40000000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rstn = 1'b0;
        @(posedge clk); #1;
        chk("abort_req_ready", req_ready == 1'b1, 32'(req_ready), 32'd1);
        chk("abort_resp_valid", resp_valid == 1'b0, 32'(resp_valid), 32'd0);
        chk("abort_y", y == 32'h0, y, 32'h0);
        @(negedge clk); rstn = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("abort_no_resp", seen == 1'b0, 32'(seen), 32'd0);

        // Back-to-back: req_valid held with 3 operand pairs
        pa[0] = 32'h40C00000; pb[0] = 32'h40000000; pexp[0] = 32'h40400000;
        pa[1] = 32'hC1200000; pb[1] = 32'h40800000; pexp[1] = 32'hC0200000;
        pa[2] = 32'h40E00000; pb[2] = 32'hBF000000; pexp[2] = 32'hC1600000;
        idx = 0; nresp = 0;
        for (int cyc = 0; cyc < 200 && nresp < 3; cyc++) begin
            @(negedge clk);
            req_valid = (idx < 3);
            if (idx < 3) begin a1 = pa[idx]; a2 = pb[idx]; end
            rdy = req_ready; rv = resp_valid;
            if (rv && nresp < 3) got[nresp] = y;
            @(posedge clk);
            if (rdy && idx < 3) idx++;
            if (rv) nresp++;
        end
        @(negedge clk); req_valid = 1'b0;
        chk("b2b_accepted", idx == 3, 32'(idx), 32'd3);
        chk("b2b_responses", nresp == 3, 32'(nresp), 32'd3);
        for (int i = 0; i < 3 && i < nresp; i++) begin
            $display("b2b resp%0d y=%08h", i, got[i]);
            chk($sformatf("b2b_y%0d", i), ulp_dist(got[i], pexp[i]) <= 3, got[i], pexp[i]);
        end
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("b2b_no_dup", seen == 1'b0, 32'(seen), 32'd0);

        // Exponent sweep: all divisor exponents, both signs, fixed and random mantissas
        for (int e2 = 1; e2 <= 253; e2++) begin
            for (int sg = 0; sg < 2; sg++) begin
                for (int k = 0; k < 2; k++) begin
                    bx2 = {sg[0], e2[7:0], (k == 0) ? 23'h0 : 23'($urandom)};
                    bx1 = {1'($urandom), 8'd127, 23'($urandom)};
                    refy = to_single(from_single(bx1) / from_single(bx2));
                    run_op(bx1, bx2, 1'b0, yv, dzv);
                    if (refy[30:23] >= 8'd1 && refy[30:23] <= 8'd254) begin
                        ref_y0 = refy;
                        chk("sweep_y", ulp_dist(yv, ref_y0) <= 3, yv, ref_y0);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
